// File: rtl/latency_skid_fifo.sv
// latency_skid_fifo: FWFT FIFO that absorbs a fixed credit round trip.
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_ready (upstream,
//   in_ready is an early credit that reaches the source RT_LATENCY cycles
//   late); out_valid/out_data/out_ready (downstream FWFT); count (occupancy);
//   overflow (sticky drop flag, live only with LATENCY_SKID_FIFO_OVF_CHECK_EN).
module latency_skid_fifo #(
    parameter int WIDTH      = 512,
    parameter int DEPTH      = 32,
    parameter int RT_LATENCY = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    // count + RT_LATENCY < DEPTH, rearranged to avoid widening count.
    localparam logic [CW-1:0] THR = CW'(DEPTH - RT_LATENCY);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             push;
    logic             pop;

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign in_ready  = (count < THR);

    // in_valid is taken regardless of in_ready; only a truly full FIFO
    // without a same-cycle pop refuses the beat.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && ((count != FULL) || pop);

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef LATENCY_SKID_FIFO_OVF_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_valid && !push) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_latency_skid_fifo.sv
// tb_latency_skid_fifo: directed bench with a queue-based reference model.
// Per-cycle compare on negedge plus literal checks after directed steps.
module tb_latency_skid_fifo;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int RT = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [4:0]   count;
    logic         overflow;

    int total = 0;
    int bad   = 0;
    bit live  = 0;

    logic [W-1:0] q[$];
    bit           m_ovf;

`ifdef LATENCY_SKID_FIFO_OVF_CHECK_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    latency_skid_fifo #(
        .WIDTH(W),
        .DEPTH(D),
        .RT_LATENCY(RT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .count(count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference model: a plain queue with the accept/drop rules.
    always @(posedge clk) begin
        bit p_pop;
        bit p_push;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            p_pop  = (q.size() != 0) && out_ready;
            p_push = in_valid && (q.size() < D || p_pop);
            if (in_valid && !p_push && OVF_ON) m_ovf = 1'b1;
            if (p_pop) void'(q.pop_front());
            if (p_push) q.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("m_in_ready", 32'(in_ready), 32'(q.size() + RT < D));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            if (q.size() != 0) chk("m_out_data", 32'(out_data), 32'(q[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        live = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Fill to 12, watching in_ready drop exactly at 12.
        for (int i = 1; i <= 12; i++) begin
            in_valid = 1'b1;
            in_data = W'(i);
            step();
            if (i == 11) chk("rdy_at_11", 32'(in_ready), 32'd1);
            if (i == 12) chk("rdy_at_12", 32'(in_ready), 32'd0);
        end
        for (int i = 13; i <= 16; i++) begin
            in_data = W'(i);
            step();
        end
        chk("full_count", 32'(count), 32'd16);
        chk("full_ovf", 32'(overflow), 32'd0);
        chk("full_head", 32'(out_data), 32'h01);

        // Beat into a full FIFO with no pop is dropped.
        in_data = 8'hAA;
        step();
        in_valid = 1'b0;
        chk("drop_count", 32'(count), 32'd16);
        chk("drop_ovf", 32'(overflow), 32'(OVF_ON));
        step();
        chk("drop_sticky", 32'(overflow), 32'(OVF_ON));

        // Full with simultaneous push/pop for 20 cycles.
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = W'(8'h20 + k);
            step();
        end
        in_valid = 1'b0;
        chk("stream_count", 32'(count), 32'd16);
        chk("stream_head", 32'(out_data), 32'h24);

        // Drain, bounded.
        n = 0;
        while (count != 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_done", 32'(count), 32'd0);

        // Latency-1 visibility.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h5A);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("lat_pop", 32'(out_valid), 32'd0);

        // Mid-operation reset with a beat presented.
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = W'(8'h40 + i);
            step();
        end
        chk("pre_rst_count", 32'(count), 32'd9);
        rst = 1'b1;
        in_data = 8'h77;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        in_valid = 1'b1;
        in_data = 8'h33;
        step();
        in_valid = 1'b0;
        chk("post_rst_data", 32'(out_data), 32'h33);
        chk("post_rst_count", 32'(count), 32'd1);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
